// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// FSM encodings, MDU op codes and counter width.
package pipeline_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MDU_NONE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_op_e;

endpackage

// File: rtl/pipeline_ctrl_mdu_seq.sv
// MDU sequencer: latency down-counter, start pulse, busy flag and
// HI/LO write pulse in the last busy cycle.
module mdu_seq
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] op,
    output logic       mduStart,
    output logic       mduBusy,
    output logic       hiloWrite
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             is_op;

    assign is_op     = (op == MDU_MUL) || (op == MDU_DIV);
    assign mduStart  = run && is_op && (cnt_q == '0);
    assign mduBusy   = (cnt_q != '0);
    assign hiloWrite = (cnt_q == CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (mduStart) begin
            cnt_d = (op == MDU_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        end else if (cnt_q != '0) begin
            // keeps counting through memory freezes
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional PIPE_STALL_STATS_EN adds saturating stall/flush/freeze counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 12,
    parameter int RESET_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead_ID_EX,
    input  logic [4:0]  rt_ID_EX,
    input  logic [4:0]  rs_IF_ID,
    input  logic [4:0]  rt_IF_ID,
    input  logic        useRt_IF_ID,
    input  logic        hiloUse_IF_ID,
    input  logic [1:0]  mduOp_ID_EX,
    input  logic        branchTaken_EX,
    input  logic        memBusy,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        exMemWrite,
    output logic        memWbWrite,
    output logic        mduStart,
    output logic        mduBusy,
    output logic        hiloWrite
`ifdef PIPE_STALL_STATS_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCount,
    output logic [31:0] freezeCycles
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             active, run, freeze;
    logic             load_use, hilo_stall;
    logic             seq_start, seq_busy, seq_hilo;

    // RUN and FREEZE both behave as "freeze" while memBusy is high
    assign active = (state_q == RUN) || (state_q == FREEZE);
    assign run    = active && !memBusy;
    assign freeze = active && memBusy;

    assign load_use = memRead_ID_EX && (rt_ID_EX != 5'd0) &&
                      ((rt_ID_EX == rs_IF_ID) ||
                       (useRt_IF_ID && (rt_ID_EX == rt_IF_ID)));
    assign hilo_stall = hiloUse_IF_ID && (seq_busy || seq_start);

    mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .op        (mduOp_ID_EX),
        .mduStart  (seq_start),
        .mduBusy   (seq_busy),
        .hiloWrite (seq_hilo)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - CNT_W'(1);
                end
                if (hold_q <= CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN, FREEZE: begin
                state_d = memBusy ? FREEZE : RUN;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_comb begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        exMemWrite = 1'b0;
        memWbWrite = 1'b0;
        mduStart   = 1'b0;
        mduBusy    = 1'b0;
        hiloWrite  = 1'b0;
        if (!active) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else begin
            mduBusy   = seq_busy;
            hiloWrite = seq_hilo;
            mduStart  = seq_start;
            if (run) begin
                exMemWrite = 1'b1;
                memWbWrite = 1'b1;
                // a taken branch kills the ID instruction, so no stall needed
                if (branchTaken_EX) begin
                    pcWrite   = 1'b1;
                    ifIdWrite = 1'b1;
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                end else if (load_use || hilo_stall) begin
                    idExFlush = 1'b1;
                end else begin
                    pcWrite   = 1'b1;
                    ifIdWrite = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
            hold_q  <= CNT_W'(RESET_HOLD);
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;
    logic [31:0] frz_q, frz_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        frz_d   = frz_q;
        if (run && !branchTaken_EX && (load_use || hilo_stall) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (run && branchTaken_EX && (flush_q != '1)) begin
            flush_d = flush_q + 32'd1;
        end
        if (freeze && (frz_q != '1)) begin
            frz_d = frz_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            frz_q   <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            frz_q   <= frz_d;
        end
    end

    assign stallCycles  = stall_q;
    assign flushCount   = flush_q;
    assign freezeCycles = frz_q;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead_ID_EX;
    logic [4:0]  rt_ID_EX, rs_IF_ID, rt_IF_ID;
    logic        useRt_IF_ID, hiloUse_IF_ID;
    logic [1:0]  mduOp_ID_EX;
    logic        branchTaken_EX, memBusy;
    logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush;
    logic        exMemWrite, memWbWrite, mduStart, mduBusy, hiloWrite;
`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stallCycles, flushCount, freezeCycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int hilo_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MUL_LAT    (4),
        .DIV_LAT    (12),
        .RESET_HOLD (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .memRead_ID_EX  (memRead_ID_EX),
        .rt_ID_EX       (rt_ID_EX),
        .rs_IF_ID       (rs_IF_ID),
        .rt_IF_ID       (rt_IF_ID),
        .useRt_IF_ID    (useRt_IF_ID),
        .hiloUse_IF_ID  (hiloUse_IF_ID),
        .mduOp_ID_EX    (mduOp_ID_EX),
        .branchTaken_EX (branchTaken_EX),
        .memBusy        (memBusy),
        .pcWrite        (pcWrite),
        .ifIdWrite      (ifIdWrite),
        .ifIdFlush      (ifIdFlush),
        .idExFlush      (idExFlush),
        .exMemWrite     (exMemWrite),
        .memWbWrite     (memWbWrite),
        .mduStart       (mduStart),
        .mduBusy        (mduBusy),
        .hiloWrite      (hiloWrite)
`ifdef PIPE_STALL_STATS_EN
        ,
        .stallCycles    (stallCycles),
        .flushCount     (flushCount),
        .freezeCycles   (freezeCycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memRead_ID_EX  = 1'b0;
        rt_ID_EX       = 5'd0;
        rs_IF_ID       = 5'd0;
        rt_IF_ID       = 5'd0;
        useRt_IF_ID    = 1'b0;
        hiloUse_IF_ID  = 1'b0;
        mduOp_ID_EX    = 2'd0;
        branchTaken_EX = 1'b0;
        memBusy        = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        #1;
        check("rst_pcWrite", pcWrite, 0);
        check("rst_ifIdFlush", ifIdFlush, 1);
        check("rst_idExFlush", idExFlush, 1);
        check("rst_exMemWrite", exMemWrite, 0);
        check("rst_mduBusy", mduBusy, 0);

        // release: two HOLD cycles, then RUN
        step();
        rst = 1'b0;
        #1;
        check("hold0_pcWrite", pcWrite, 0);
        check("hold0_ifIdFlush", ifIdFlush, 1);
        step();
        #1;
        check("hold1_pcWrite", pcWrite, 0);
        check("hold1_idExFlush", idExFlush, 1);
        step();
        #1;
        check("run_pcWrite", pcWrite, 1);
        check("run_ifIdFlush", ifIdFlush, 0);
        check("run_exMemWrite", exMemWrite, 1);

        // load-use on rs
        memRead_ID_EX = 1'b1; rt_ID_EX = 5'd5; rs_IF_ID = 5'd5;
        #1;
        check("lu_pcWrite", pcWrite, 0);
        check("lu_ifIdWrite", ifIdWrite, 0);
        check("lu_idExFlush", idExFlush, 1);
        check("lu_memWbWrite", memWbWrite, 1);
        step();
        rt_ID_EX = 5'd0; rs_IF_ID = 5'd0;
        #1;
        check("lu_r0_pcWrite", pcWrite, 1);
        check("lu_r0_idExFlush", idExFlush, 0);
        // load-use on rt depends on useRt
        step();
        rt_ID_EX = 5'd7; rs_IF_ID = 5'd3; rt_IF_ID = 5'd7; useRt_IF_ID = 1'b1;
        #1;
        check("lu_rt_pcWrite", pcWrite, 0);
        useRt_IF_ID = 1'b0;
        #1;
        check("lu_rt_unused_pcWrite", pcWrite, 1);

        // branch beats load-use
        step();
        rt_ID_EX = 5'd5; rs_IF_ID = 5'd5; branchTaken_EX = 1'b1;
        #1;
        check("br_pcWrite", pcWrite, 1);
        check("br_ifIdWrite", ifIdWrite, 1);
        check("br_ifIdFlush", ifIdFlush, 1);
        check("br_idExFlush", idExFlush, 1);
        branchTaken_EX = 1'b0;

        // memBusy freezes everything for 3 cycles, then the bubble
        for (int i = 0; i < 3; i++) begin
            step();
            memBusy = 1'b1;
            #1;
            check("frz_pcWrite", pcWrite, 0);
            check("frz_ifIdWrite", ifIdWrite, 0);
            check("frz_idExFlush", idExFlush, 0);
            check("frz_ifIdFlush", ifIdFlush, 0);
            check("frz_exMemWrite", exMemWrite, 0);
            check("frz_memWbWrite", memWbWrite, 0);
        end
        step();
        memBusy = 1'b0;
        #1;
        check("post_frz_pcWrite", pcWrite, 0);
        check("post_frz_idExFlush", idExFlush, 1);
        check("post_frz_exMemWrite", exMemWrite, 1);

        // divide in EX, mfhi held in ID
        step();
        idle_inputs();
        mduOp_ID_EX = 2'd2; hiloUse_IF_ID = 1'b1;
        #1;
        check("div_start", mduStart, 1);
        check("div_ifIdWrite", ifIdWrite, 0);
        check("div_idExFlush", idExFlush, 1);
        hilo_cnt = 0;
        for (int k = 1; k <= 13; k++) begin
            step();
            mduOp_ID_EX = 2'd0;
            memBusy = (k == 5 || k == 6);
            #1;
            check("div_no_restart", mduStart, 0);
            check("div_busy", mduBusy, (k <= 12) ? 1 : 0);
            check("div_hilo", hiloWrite, (k == 12) ? 1 : 0);
            check("div_ifIdWrite_k", ifIdWrite, (k == 13) ? 1 : 0);
        end

        // reset aborts a multiply in flight
        step();
        idle_inputs();
        mduOp_ID_EX = 2'd1;
        #1;
        check("mul_start", mduStart, 1);
        step();
        mduOp_ID_EX = 2'd0;
        #1;
        check("mul_busy", mduBusy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", mduBusy, 0);
        check("abort_hilo", hiloWrite, 0);
        check("abort_pcWrite", pcWrite, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (hiloWrite) hilo_cnt++;
            step();
        end
        check("abort_no_hilo", hilo_cnt, 0);
        check("abort_run_pcWrite", pcWrite, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
